// File: rtl/gain_ramp_if.sv
// Request channel for gain_ramp_ctrl: one band/gain update per valid/ready handshake.
interface gain_ramp_if;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_band;
    logic signed [7:0] req_gain;

    modport master (output req_valid, output req_band, output req_gain, input req_ready);
    modport slave  (input req_valid, input req_band, input req_gain, output req_ready);
endinterface

// File: rtl/gain_ramp_ctrl.sv
// Three-band gain ramp controller: each band gain moves one unit toward its target
// every STEP_DIV sample ticks; targets are written through a single pending request slot.
module gain_ramp_ctrl #(
    parameter int unsigned       STEP_DIV     = 16,
    parameter logic signed [7:0] DEFAULT_GAIN = 8'sd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    gain_ramp_if.slave        rif,
    output logic signed [7:0] gain [0:2],
    output logic              busy,
    output logic              err_band
);

    localparam logic [15:0] CNT_LAST = 16'(STEP_DIV - 1);

    typedef enum logic {ST_IDLE, ST_APPLY} state_t;

    state_t            state_q, state_d;
    logic [1:0]        pend_band_q, pend_band_d;
    logic signed [7:0] pend_gain_q, pend_gain_d;
    logic [15:0]       cnt_q, cnt_d;
    logic signed [7:0] gain_q   [0:2];
    logic signed [7:0] gain_d   [0:2];
    logic signed [7:0] target_q [0:2];
    logic signed [7:0] target_d [0:2];
    logic [2:0]        neq;
    logic              accept;
    logic              apply;
    logic              step_evt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_band_q <= 2'd0;
            pend_gain_q <= 8'sd0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            pend_band_q <= pend_band_d;
            pend_gain_q <= pend_gain_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_APPLY;
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs of the request FSM; ready is masked by reset so it reads 0 while reset is held
    always_comb begin
        rif.req_ready = (state_q == ST_IDLE) && !reset;
        apply         = (state_q == ST_APPLY);
        err_band      = apply && (pend_band_q == 2'd3) && !reset;
    end

    assign accept = rif.req_valid && rif.req_ready;

    always_comb begin
        pend_band_d = pend_band_q;
        pend_gain_d = pend_gain_q;
        if (accept) begin
            pend_band_d = rif.req_band;
            pend_gain_d = rif.req_gain;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sample_tick) cnt_d = (cnt_q == CNT_LAST) ? 16'd0 : cnt_q + 16'd1;
    end

    assign step_evt = sample_tick && (cnt_q == CNT_LAST);

    // Per-band ramp: steps compare against the target held before this edge
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_band
            assign target_d[gi] = (apply && pend_band_q == 2'(gi)) ? pend_gain_q : target_q[gi];

            assign gain_d[gi] = !step_evt                  ? gain_q[gi] :
                                (gain_q[gi] < target_q[gi]) ? gain_q[gi] + 8'sd1 :
                                (gain_q[gi] > target_q[gi]) ? gain_q[gi] - 8'sd1 :
                                                              gain_q[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    gain_q[gi]   <= DEFAULT_GAIN;
                    target_q[gi] <= DEFAULT_GAIN;
                end else begin
                    gain_q[gi]   <= gain_d[gi];
                    target_q[gi] <= target_d[gi];
                end
            end

            assign neq[gi]  = (gain_q[gi] != target_q[gi]);
            assign gain[gi] = gain_q[gi];
        end
    endgenerate

    assign busy = |neq;

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Randomized scoreboard bench for gain_ramp_ctrl with a tick-counting reference model.
module tb_gain_ramp_ctrl;

    localparam int STEP_DIV = 4;
    localparam int DEF_GAIN = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_tick;
    logic signed [7:0] gain_w [0:2];
    logic              busy;
    logic              err_band;

    gain_ramp_if rif ();

    gain_ramp_ctrl #(.STEP_DIV(STEP_DIV), .DEFAULT_GAIN(8'sd1)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rif         (rif),
        .gain        (gain_w),
        .busy        (busy),
        .err_band    (err_band)
    );

    always #5 clk = ~clk;

    typedef struct {
        int g0;
        int g1;
        int g2;
        int busy;
        int ready;
        int err;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: gains/targets as plain ints, step events from a running tick total
    int m_gain   [3];
    int m_target [3];
    int m_ticks;
    bit m_pend;
    int m_pband;
    int m_pgain;

    task automatic check(input string name, input int c, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_gain[b]   = DEF_GAIN;
            m_target[b] = DEF_GAIN;
        end
        m_ticks = 0;
        m_pend  = 1'b0;
    endtask

    task automatic cycle(input bit rst, input bit tick, input bit vld, input int band, input int g);
        exp_t e;
        bit   any_diff;
        reset           = rst;
        sample_tick     = tick;
        rif.req_valid   = vld;
        rif.req_band    = band[1:0];
        rif.req_gain    = g[7:0];
        any_diff = 1'b0;
        for (int b = 0; b < 3; b++) if (m_gain[b] != m_target[b]) any_diff = 1'b1;
        e.g0    = m_gain[0];
        e.g1    = m_gain[1];
        e.g2    = m_gain[2];
        e.busy  = int'(any_diff);
        e.ready = int'(!rst && !m_pend);
        e.err   = int'(!rst && m_pend && m_pband == 3);
        e.cyc   = cyc;
        exp_q.push_back(e);
        if (rst) begin
            model_reset();
        end else begin
            if (tick) begin
                if ((m_ticks % STEP_DIV) == STEP_DIV - 1) begin
                    for (int b = 0; b < 3; b++) begin
                        if (m_gain[b] < m_target[b]) m_gain[b]++;
                        else if (m_gain[b] > m_target[b]) m_gain[b]--;
                    end
                end
                m_ticks++;
            end
            if (m_pend) begin
                if (m_pband != 3) m_target[m_pband] = m_pgain;
                m_pend = 1'b0;
            end else if (vld) begin
                m_pend  = 1'b1;
                m_pband = band;
                m_pgain = g;
                $display("req cycle=%0d band=%0d gain=%0d", cyc, band, g);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gain0",     e.cyc, int'(gain_w[0]),    e.g0);
                check("gain1",     e.cyc, int'(gain_w[1]),    e.g1);
                check("gain2",     e.cyc, int'(gain_w[2]),    e.g2);
                check("busy",      e.cyc, int'(busy),         e.busy);
                check("req_ready", e.cyc, int'(rif.req_ready), e.ready);
                check("err_band",  e.cyc, int'(err_band),     e.err);
            end
        end
    end

    initial begin
        int g;
        reset         = 1'b1;
        sample_tick   = 1'b0;
        rif.req_valid = 1'b0;
        rif.req_band  = 2'd0;
        rif.req_gain  = 8'sd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset hold and release
        repeat (2) cycle(1, 1, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0);

        // Band1 ramp up to 4
        cycle(0, 1, 1, 1, 4);
        repeat (20) cycle(0, 1, 0, 0, 0);

        // Band0 ramp down to -3, with valid held through the busy cycle
        cycle(0, 1, 1, 0, -3);
        cycle(0, 1, 1, 0, -3);
        repeat (22) cycle(0, 1, 0, 0, 0);

        // Illegal band
        cycle(0, 1, 1, 3, 50);
        repeat (4) cycle(0, 1, 0, 0, 0);

        // Band2 toward 10, redirected to 0 with the apply landing on a step event
        cycle(0, 1, 1, 2, 10);
        for (int i = 0; i < 200 && !(m_gain[2] == 3 && (m_ticks % STEP_DIV) == 2); i++)
            cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 2, 0);
        repeat (24) cycle(0, 1, 0, 0, 0);

        // Reset mid-ramp with a request pending, then ticks held low
        cycle(0, 1, 1, 1, 4);
        for (int i = 0; i < 200 && m_gain[1] != 2; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 7);
        cycle(1, 1, 1, 2, 9);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, -5);
        repeat (12) cycle(0, 0, 0, 0, 0);
        repeat (8) cycle(0, 1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 4) == 0) g = int'($urandom_range(0, 255)) - 128;
            else g = int'($urandom_range(0, 16)) - 8;
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)), g);
        end
        repeat (3) cycle(0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d expected=0 pending records", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
